first_counter: RTL and testbench
================================

// Module: first_counter
//
// PURPOSE
//   Free-running up-counter with synchronous clear and a count-enable.
//   Used as a basic event and cycle counter. Its value feeds status
//   and display logic downstream.
//   Single clock domain. Output is registered, with no combinational path from
//   input to output.
//
// PARAMETERS
//   WIDTH        4    counter width in bits; legal range 1..32
//   RESET_VALUE  0    value loaded on reset; must fit in WIDTH bits
//
// PORTS
//   clock        in   1      rising-edge clock, the only clock domain
//   reset        in   1      synchronous, active-high clear
//   enable       in   1      count enable, active-high
//   counter_out  out  WIDTH  current count, driven directly from the register
//   overflow     out  1      wrap pulse; present only with FIRST_COUNTER_OVF_EN
//   Positional port order is clock, reset, enable, counter_out, then overflow.
//   Existing instances connect the ports by position.
//
// BEHAVIOUR
//   - All state updates on the rising edge of clock only.
//   - Reset is synchronous and active-high. There is no asynchronous path.
//     reset=1 at an edge: counter_out <= RESET_VALUE.
//   - Reset has priority over enable. reset=1 with enable=1 still clears.
//   - reset=0, enable=1: counter_out <= counter_out + 1, modulo 2**WIDTH.
//   - reset=0, enable=0: counter_out holds its value.
//   - Latency: 1 cycle. A change on enable affects the count at the next edge.
//   - Wrap-around: at all-ones with enable=1, the next value is 0. The counter
//     does not saturate and does not stop.
//   - Reset mid-count: any partial count is discarded. Counting resumes from
//     RESET_VALUE on the first enabled edge after reset deasserts.
//   - After power-up and before the first reset, counter_out is undefined.
//     Users must apply reset for at least 1 edge.
//   - An X on enable while reset=0 is a user error. No recovery is required.
//
// CONFIGURATION
//   FIRST_COUNTER_OVF_EN defined:
//     - Adds the registered output overflow.
//     - overflow=1 for exactly the cycle following an edge where
//       counter_out == 2**WIDTH-1, enable=1 and reset=0. That cycle is the
//       one in which counter_out shows 0.
//     - overflow=0 in all other cycles, and is cleared by reset.
//     - If enable stays high, overflow pulses once every 2**WIDTH cycles.
//   FIRST_COUNTER_OVF_EN undefined:
//     - The overflow port and its register are absent.
//     - Counter behaviour is otherwise identical.
//
// TESTING  (WIDTH=4, RESET_VALUE=0, clock period 10; drive inputs on the
//           falling edge)
//   1. reset=1 for 1 edge, enable=0 -> counter_out=0, and it holds 0 over
//      5 further edges.
//   2. After reset, enable=1 for 10 edges -> counter_out steps 1,2,...,10.
//      Drop enable -> it holds 10.
//   3. enable=1 for 16 edges from 0 -> the value after 15 is 0.
//      With FIRST_COUNTER_OVF_EN: overflow=1 for that one cycle only.
//   4. At count 7, assert reset and enable together for 1 edge -> 0.
//      On the next enabled edge -> 1.
//   5. Toggle enable every edge for 8 edges from 0 -> final count 4.
//      overflow stays 0 throughout.
//   6. RESET_VALUE=5, WIDTH=3 -> after reset 5. Three enabled edges give
//      6, 7, 0. overflow (if built) is 1 only in the cycle showing 0.

Source files
------------

// File: rtl/first_counter_if.sv
// Counter control/status bundle. The overflow signal exists only when
// FIRST_COUNTER_OVF_EN is defined.
interface first_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] counter_out;
`ifdef FIRST_COUNTER_OVF_EN
    logic             overflow;
`endif

`ifdef FIRST_COUNTER_OVF_EN
    modport master (output reset, output enable, input counter_out, input overflow);
    modport slave  (input reset, input enable, output counter_out, output overflow);
`else
    modport master (output reset, output enable, input counter_out);
    modport slave  (input reset, input enable, output counter_out);
`endif
endinterface

// File: rtl/first_counter.sv
// Free-running up-counter with synchronous clear and count-enable.
// Optional registered wrap pulse on overflow when FIRST_COUNTER_OVF_EN is defined.
module first_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out
`ifdef FIRST_COUNTER_OVF_EN
   ,output logic             overflow
`endif
);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap;

    // Reset outranks enable; the wrap condition only matters when counting.
    always_comb begin
        w_count_next = r_count;
        w_wrap       = 1'b0;
        if (enable) begin
            w_count_next = r_count + WIDTH'(1);
            w_wrap       = (r_count == ALL_ONES);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign counter_out = r_count;

`ifdef FIRST_COUNTER_OVF_EN
    logic r_overflow;

    // High exactly in the cycle where the count shows its post-wrap zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_wrap;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_wrap_unused;
    assign w_wrap_unused = w_wrap;
`endif

endmodule

// File: tb/tb_first_counter.sv
// Bench for first_counter: a 4-bit/reset-0 instance driven from a vector
// table and a 3-bit/reset-5 instance driven by a hand-written sequence.
module tb_first_counter;
    logic clk;

    first_counter_if #(.WIDTH(4)) ifa ();
    first_counter_if #(.WIDTH(3)) ifb ();

    first_counter #(.WIDTH(4), .RESET_VALUE(0)) dut_a (
        .clock       (clk),
        .reset       (ifa.reset),
        .enable      (ifa.enable),
        .counter_out (ifa.counter_out)
`ifdef FIRST_COUNTER_OVF_EN
       ,.overflow    (ifa.overflow)
`endif
    );

    first_counter #(.WIDTH(3), .RESET_VALUE(5)) dut_b (
        .clock       (clk),
        .reset       (ifb.reset),
        .enable      (ifb.enable),
        .counter_out (ifb.counter_out)
`ifdef FIRST_COUNTER_OVF_EN
       ,.overflow    (ifb.overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] cnt;
        logic       ovf;
        string      name;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [3:0] cnt;
        logic       ovf;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input logic r, input logic en, input int c,
                                input logic o, input string nm);
        vec_t v;
        v.rst = r; v.en = en; v.cnt = 4'(c); v.ovf = o; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check_out();
        exp_t       e;
        logic [3:0] got_c;
        logic       got_o;
        e     = sb.pop_front();
        got_c = e.sel ? {1'b0, ifb.counter_out} : ifa.counter_out;
        got_o = 1'b0;
`ifdef FIRST_COUNTER_OVF_EN
        got_o = e.sel ? ifb.overflow : ifa.overflow;
`endif
        checks++;
        if (got_c !== e.cnt) begin
            failures++;
            $display("FAIL %s: counter_out got %0d expected %0d at %0t",
                     e.name, got_c, e.cnt, $time);
        end
`ifdef FIRST_COUNTER_OVF_EN
        checks++;
        if (got_o !== e.ovf) begin
            failures++;
            $display("FAIL %s_ovf: overflow got %b expected %b at %0t",
                     e.name, got_o, e.ovf, $time);
        end
`else
        if (got_o !== 1'b0) $display("unexpected overflow state");
`endif
    endtask

    // Drive on the falling edge, push the expectation, sample 1 after the rising edge.
    task automatic apply(input bit sel, input logic r, input logic en,
                         input logic [3:0] c, input logic o, input string nm);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            ifb.reset = r; ifb.enable = en;
        end else begin
            ifa.reset = r; ifa.enable = en;
        end
        e.sel = sel; e.cnt = c; e.ovf = o; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        ifa.reset = 1'b1; ifa.enable = 1'b0;
        ifb.reset = 1'b1; ifb.enable = 1'b0;

        // 1: reset then hold at zero
        add(1, 0, 0, 0, "t1_reset");
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, "t1_hold");
        // 2: count 1..10 then hold
        for (int i = 1; i <= 10; i++) add(0, 1, i, 0, "t2_count");
        add(0, 0, 10, 0, "t2_hold");
        add(0, 0, 10, 0, "t2_hold");
        // 3: full wrap from 0; overflow only in the cycle showing 0
        add(1, 0, 0, 0, "t3_reset");
        for (int i = 1; i <= 15; i++) add(0, 1, i, 0, "t3_count");
        add(0, 1, 0, 1, "t3_wrap");
        add(0, 0, 0, 0, "t3_after");
        // 4: reset with enable at count 7
        for (int i = 1; i <= 7; i++) add(0, 1, i, 0, "t4_count");
        add(1, 1, 0, 0, "t4_rst_en");
        add(0, 1, 1, 0, "t4_resume");
        // 5: toggled enable from 0
        add(1, 0, 0, 0, "t5_reset");
        for (int i = 0; i < 8; i++) add(0, (i % 2 == 0), (i / 2) + 1, 0, "t5_toggle");
        // reset discards a wrap that would otherwise happen at all-ones
        for (int i = 5; i <= 15; i++) add(0, 1, i, 0, "t5b_count");
        add(1, 1, 0, 0, "t5b_rst_at_max");
        add(0, 0, 0, 0, "t5b_after");

        foreach (vecs[i]) apply(1'b0, vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].ovf, vecs[i].name);

        // 6: WIDTH=3, RESET_VALUE=5
        apply(1'b1, 1, 0, 4'd5, 1'b0, "t6_reset");
        apply(1'b1, 0, 1, 4'd6, 1'b0, "t6_six");
        apply(1'b1, 0, 1, 4'd7, 1'b0, "t6_seven");
        apply(1'b1, 0, 1, 4'd0, 1'b1, "t6_wrap");
        apply(1'b1, 0, 1, 4'd1, 1'b0, "t6_one");
        apply(1'b1, 0, 0, 4'd1, 1'b0, "t6_hold");
        apply(1'b1, 1, 0, 4'd5, 1'b0, "t6_reset2");
        apply(1'b1, 0, 1, 4'd6, 1'b0, "t6_six2");
        apply(1'b1, 0, 1, 4'd7, 1'b0, "t6_seven2");
        apply(1'b1, 1, 1, 4'd5, 1'b0, "t6_rst_at_max");
        apply(1'b1, 0, 1, 4'd6, 1'b0, "t6_resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run is purely clock-driven, so this only guards against a stuck bench.
    initial begin
        #200000;
        $display("FAIL watchdog: run got past %0t expected to finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
